// File: rtl/manchester_tx_arbiter_pkg.sv
// Shared constants for the Manchester TX arbiter: FSM state codes and counter widths.
package manchester_pkg;

  localparam int BEAT_CNT_W = 16;
  localparam int GAP_CNT_W  = 8;

  typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;
  typedef logic [GAP_CNT_W-1:0]  gap_cnt_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_PASS  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // With no inter-frame gap configured, a finished frame returns straight to IDLE.
  function automatic logic [2:0] frame_end_state(input int ifg_cycles);
    return (ifg_cycles > 0) ? ST_GAP : ST_IDLE;
  endfunction

endpackage

// File: rtl/manchester_tx_arbiter_if.sv
// AXI-Stream style byte stream bundle used for both source inputs and the arbitrated output.
interface manchester_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/manchester_tx_arbiter_rr_arbiter2.sv
// Two-way round-robin chooser; the last-grant pointer moves only when a frame completes.
module rr_arbiter2 (
  input  logic       aclk,
  input  logic       areset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       update_idx,
  output logic       pick,
  output logic       any_req
);

  logic last_grant;

  // Pointer resets to 1 so that source 0 wins the first contested arbitration.
  always_ff @(posedge aclk) begin
    if (areset) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= update_idx;
    end
  end

  always_comb begin
    any_req = |req;
    pick    = 1'b0;
    if (req[0] && req[1]) begin
      pick = ~last_grant;
    end else if (req[1]) begin
      pick = 1'b1;
    end
  end

endmodule

// File: rtl/manchester_tx_arbiter.sv
// Frame-level round-robin arbiter of two byte streams with truncation and inter-frame gap.
module manchester_tx_arbiter
  import manchester_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int IFG_CYCLES      = 12,
  parameter int MAX_FRAME_BEATS = 1518
) (
  input  logic                   aclk,
  input  logic                   areset,
  manchester_tx_arbiter_if.slave  s0_axis,
  manchester_tx_arbiter_if.slave  s1_axis,
  manchester_tx_arbiter_if.master m_axis,
  output logic                   grant,
  output logic                   busy,
  output logic                   trunc_pulse
);

  localparam beat_cnt_t  LAST_BEAT = beat_cnt_t'(MAX_FRAME_BEATS - 1);
  localparam gap_cnt_t   GAP_LAST  = gap_cnt_t'((IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0);
  localparam logic [2:0] END_STATE = frame_end_state(IFG_CYCLES);

  logic [2:0]            state;
  logic                  grant_q;
  beat_cnt_t             beat_cnt;
  gap_cnt_t              gap_cnt;

  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_valid;
  logic                  src_last;
  logic                  src_ready;
  logic                  in_pass;
  logic                  in_drain;
  logic                  at_limit;
  logic                  pass_hs;
  logic                  drain_hs;
  logic                  frame_end;
  logic                  arb_pick;
  logic                  arb_any;

  rr_arbiter2 u_rr (
    .aclk       (aclk),
    .areset     (areset),
    .req        ({s1_axis.tvalid, s0_axis.tvalid}),
    .update     (frame_end),
    .update_idx (grant_q),
    .pick       (arb_pick),
    .any_req    (arb_any)
  );

  always_comb begin
    src_data  = grant_q ? s1_axis.tdata  : s0_axis.tdata;
    src_valid = grant_q ? s1_axis.tvalid : s0_axis.tvalid;
    src_last  = grant_q ? s1_axis.tlast  : s0_axis.tlast;
  end

  assign in_pass   = (state == ST_PASS);
  assign in_drain  = (state == ST_DRAIN);
  assign at_limit  = (beat_cnt == LAST_BEAT);
  assign pass_hs   = in_pass && src_valid && m_axis.tready;
  assign drain_hs  = in_drain && src_valid;
  assign frame_end = (pass_hs || drain_hs) && src_last;

  // A source tlast on the limit beat is a normal end, so truncation requires its absence.
  assign trunc_pulse = pass_hs && !src_last && at_limit;

  always_comb begin
    m_axis.tvalid = in_pass && src_valid;
    m_axis.tlast  = in_pass && src_valid && (src_last || at_limit);
    m_axis.tdata  = in_pass ? src_data : '0;
    src_ready     = in_pass ? m_axis.tready : in_drain;
    s0_axis.tready = src_ready && !grant_q;
    s1_axis.tready = src_ready && grant_q;
  end

  assign grant = grant_q;
  assign busy  = (state == ST_GRANT) || in_pass || in_drain;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= ST_IDLE;
      grant_q  <= 1'b0;
      beat_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant_q <= arb_pick;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          beat_cnt <= '0;
          state    <= ST_PASS;
        end
        ST_PASS: begin
          if (pass_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (src_last) begin
              state   <= END_STATE;
              gap_cnt <= '0;
            end else if (at_limit) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_hs && src_last) begin
            state   <= END_STATE;
            gap_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
